// File: rtl/matrix_frame_writer.sv
// Double-buffered pixel writer for the matrix controller's 96-bit frame bus.
// Pixels land in a back buffer; a commit publishes it to x at the next frame_sync.

// One matrix row of the back buffer: single-pixel writes and whole-row clear.
module mfw_row #(
  parameter int COLS = 12,
  parameter int CW   = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            wr_en,
  input  logic [CW-1:0]   wr_col,
  input  logic            wr_data,
  input  logic            clr,
  output logic [COLS-1:0] bits
);
  // Row storage; clear and write never coincide because writes stop during CLEAR.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   bits <= '0;
    else if (clr)   bits <= '0;
    else if (wr_en) bits[wr_col] <= wr_data;
  end
endmodule

module matrix_frame_writer #(
  parameter int ROWS    = 8,
  parameter int COLS    = 12,
  parameter int FRAME_W = ROWS * COLS,
  parameter int RW      = 3,
  parameter int CW      = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [RW-1:0]      wr_row,
  input  logic [CW-1:0]      wr_col,
  input  logic               wr_data,
  input  logic               clear,
  input  logic               commit,
  input  logic               frame_sync,
  output logic [FRAME_W-1:0] x,
  output logic               busy,
  output logic               committed,
  output logic               err
);
  typedef enum logic [1:0] {IDLE, CLEAR, PEND} state_t;

  state_t                     state;
  logic [RW-1:0]              row_cnt;
  logic [ROWS-1:0][COLS-1:0]  back;
  logic                       wr_fire, in_range, wr_hit;

  // Ready drops during reset so nothing is accepted before the FSM is live.
  assign wr_ready = reset_n && (state == IDLE);
  assign busy     = (state != IDLE);
  assign wr_fire  = wr_valid && wr_ready;
  assign in_range = (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
  assign wr_hit   = wr_fire && in_range;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    mfw_row #(.COLS(COLS), .CW(CW)) u_row (
      .clock   (clock),
      .reset_n (reset_n),
      .wr_en   (wr_hit && (wr_row == RW'(r))),
      .wr_col  (wr_col),
      .wr_data (wr_data),
      .clr     ((state == CLEAR) && (row_cnt == RW'(r))),
      .bits    (back[r])
    );
  end

  // Control FSM: clear sweep, pending swap, and the registered err/committed pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      row_cnt   <= '0;
      x         <= '0;
      committed <= 1'b0;
      err       <= 1'b0;
    end else begin
      committed <= 1'b0;
      err       <= wr_fire && !in_range;
      case (state)
        IDLE: begin
          // clear wins over commit; the losing commit is reported
          if (clear) begin
            state   <= CLEAR;
            row_cnt <= '0;
            if (commit) err <= 1'b1;
          end else if (commit) begin
            state <= PEND;
          end
        end
        CLEAR: begin
          if (clear || commit) err <= 1'b1;
          row_cnt <= row_cnt + 1'b1;
          if (row_cnt == RW'(ROWS - 1)) state <= IDLE;
        end
        PEND: begin
          // extra commits merge into the one pending swap
          if (clear) err <= 1'b1;
          if (frame_sync) begin
            x         <= back;
            committed <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_frame_writer.sv
// Self-checking bench for matrix_frame_writer: directed scenarios plus a
// randomized run against a transaction-level model of the frame buffers.
module tb_matrix_frame_writer;
  localparam int ROWS = 8, COLS = 12, FW = 96;

  logic          clock = 1'b0, reset_n = 1'b0;
  logic          wr_valid = 0, wr_data = 0, clear = 0, commit = 0, frame_sync = 0;
  logic [2:0]    wr_row = '0;
  logic [3:0]    wr_col = '0;
  logic          wr_ready, busy, committed, err;
  logic [FW-1:0] x;

  int checks = 0, errors = 0;

  // Reference model: whole-frame buffers, clear zeroes everything at once and
  // then just blocks the writer for ROWS cycles.
  bit [FW-1:0] m_back, m_x;
  int          m_clear_left;
  bit          m_pend, m_err, m_comm;

  matrix_frame_writer dut (
    .clock(clock), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .clear(clear),
    .commit(commit), .frame_sync(frame_sync), .x(x), .busy(busy),
    .committed(committed), .err(err)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic m_reset();
    m_back = '0; m_x = '0; m_clear_left = 0; m_pend = 0; m_err = 0; m_comm = 0;
  endtask

  function automatic bit m_ready();
    return (m_clear_left == 0) && !m_pend;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic m_edge();
    if (!reset_n) begin m_reset(); return; end
    m_err = 0; m_comm = 0;
    if (m_ready()) begin
      if (wr_valid) begin
        if (int'(wr_row) < ROWS && int'(wr_col) < COLS)
          m_back[int'(wr_row) * COLS + int'(wr_col)] = wr_data;
        else m_err = 1;
      end
      if (clear) begin
        m_back = '0; m_clear_left = ROWS;
        if (commit) m_err = 1;
      end else if (commit) m_pend = 1;
    end else if (m_clear_left > 0) begin
      if (clear || commit) m_err = 1;
      m_clear_left--;
    end else begin
      if (clear) m_err = 1;
      if (frame_sync) begin m_x = m_back; m_comm = 1; m_pend = 0; end
    end
  endtask

  task automatic cyc();
    m_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit v, input int r, input int c, input bit d,
                       input bit cl, input bit cm, input bit fs);
    wr_valid = v; wr_row = 3'(r); wr_col = 4'(c); wr_data = d;
    clear = cl; commit = cm; frame_sync = fs;
  endtask

  task automatic test_reset();
    logic [FW-1:0] one;
    one = '0; one[0] = 1'b1;
    m_reset();
    #1;
    checks++;
    if (x !== '0 || busy !== 1'b0 || wr_ready !== 1'b0) begin
      errors++; $display("FAIL reset_hold x=%h busy=%b ready=%b req 0/0/0", x, busy, wr_ready);
    end
    @(posedge clock); #1; reset_n = 1'b1;
    cyc();
    checks++;
    if (wr_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release ready=%b busy=%b req 1/0", wr_ready, busy);
    end
    drive(1, 0, 0, 1, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 1, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 1); cyc();
    checks++;
    if (x !== one) begin errors++; $display("FAIL reset_setup x=%h req %h", x, one); end
    drive(0, 0, 0, 0, 1, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 0); cyc(); cyc();
    #3 reset_n = 1'b0;
    #1;
    m_reset();
    checks++;
    if (x !== '0 || busy !== 1'b0 || wr_ready !== 1'b0) begin
      errors++; $display("FAIL reset_midclear x=%h busy=%b ready=%b req 0/0/0", x, busy, wr_ready);
    end
    cyc();
    reset_n = 1'b1;
    cyc();
    checks++;
    if (wr_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle ready=%b busy=%b req 1/0", wr_ready, busy);
    end
  endtask

  task automatic test_write();
    logic [FW-1:0] exp;
    exp = '0; exp[29] = 1'b1;
    drive(1, 2, 5, 1, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 1, 0); cyc();
    checks++;
    if (busy !== 1'b1 || wr_ready !== 1'b0) begin
      errors++; $display("FAIL write_pend busy=%b ready=%b req 1/0", busy, wr_ready);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      cyc();
      checks++;
      if (x !== '0 || committed !== 1'b0) begin
        errors++; $display("FAIL write_presync x=%h committed=%b req 0/0", x, committed);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 1); cyc();
    checks++;
    if (x !== exp || committed !== 1'b1) begin
      errors++; $display("FAIL write_swap x=%h committed=%b req %h/1", x, committed, exp);
    end
    drive(0, 0, 0, 0, 0, 0, 0); cyc();
    checks++;
    if (committed !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL write_pulse committed=%b busy=%b req 0/0", committed, busy);
    end
  endtask

  task automatic test_out_of_range();
    logic [FW-1:0] exp;
    exp = '0; exp[29] = 1'b1;
    drive(1, 3, 12, 1, 0, 0, 0); cyc();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL oor_err err=%b req 1", err); end
    drive(0, 0, 0, 0, 0, 0, 0); cyc();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL oor_err_pulse err=%b req 0", err); end
    drive(0, 0, 0, 0, 0, 1, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 1); cyc();
    checks++;
    if (x !== exp || committed !== 1'b1) begin
      errors++; $display("FAIL oor_x x=%h committed=%b req %h/1", x, committed, exp);
    end
    drive(0, 0, 0, 0, 0, 0, 0); cyc();
  endtask

  task automatic test_clear();
    logic [FW-1:0] ones;
    ones = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        drive(1, r, c, 1, 0, 0, 0); cyc();
      end
    drive(0, 0, 0, 0, 0, 1, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 1); cyc();
    checks++;
    if (x !== ones) begin errors++; $display("FAIL clear_fill x=%h req %h", x, ones); end
    drive(0, 0, 0, 0, 1, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < ROWS; i++) begin
      checks++;
      if (busy !== 1'b1 || wr_ready !== 1'b0 || x !== ones) begin
        errors++; $display("FAIL clear_window cyc=%0d busy=%b ready=%b x=%h req 1/0/ones", i, busy, wr_ready, x);
      end
      cyc();
    end
    checks++;
    if (busy !== 1'b0 || wr_ready !== 1'b1) begin
      errors++; $display("FAIL clear_done busy=%b ready=%b req 0/1", busy, wr_ready);
    end
    drive(0, 0, 0, 0, 0, 1, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 1); cyc();
    checks++;
    if (x !== '0 || committed !== 1'b1) begin
      errors++; $display("FAIL clear_x x=%h committed=%b req 0/1", x, committed);
    end
    drive(0, 0, 0, 0, 0, 0, 0); cyc();
  endtask

  task automatic test_simultaneous();
    logic [FW-1:0] exp;
    drive(0, 0, 0, 0, 1, 1, 0); cyc();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL simul_clr_cm err=%b req 1", err); end
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < ROWS; i++) cyc();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL simul_no_pend busy=%b req 0", busy); end
    drive(0, 0, 0, 0, 0, 0, 1); cyc();
    checks++;
    if (committed !== 1'b0) begin errors++; $display("FAIL simul_no_swap committed=%b req 0", committed); end
    exp = '0; exp[0] = 1'b1;
    drive(1, 0, 0, 1, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 1, 1); cyc();
    checks++;
    if (committed !== 1'b0 || busy !== 1'b1 || x !== '0) begin
      errors++; $display("FAIL simul_cm_fs committed=%b busy=%b x=%h req 0/1/0", committed, busy, x);
    end
    drive(0, 0, 0, 0, 0, 0, 1); cyc();
    checks++;
    if (committed !== 1'b1 || x !== exp) begin
      errors++; $display("FAIL simul_next_fs committed=%b x=%h req 1/%h", committed, x, exp);
    end
    exp[95] = 1'b1;
    drive(1, 7, 11, 1, 0, 1, 0); cyc();
    drive(0, 0, 0, 0, 0, 0, 1); cyc();
    checks++;
    if (committed !== 1'b1 || x !== exp) begin
      errors++; $display("FAIL simul_wr_cm committed=%b x=%h req 1/%h", committed, x, exp);
    end
    drive(0, 0, 0, 0, 0, 0, 0); cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 8), $urandom_range(0, 12),
            $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 15);
      cyc();
      checks++;
      if (x !== m_x || committed !== m_comm || err !== m_err ||
          wr_ready !== m_ready() || busy !== !m_ready()) begin
        errors++;
        $display("FAIL random cyc=%0d x=%h c=%b e=%b rdy=%b busy=%b req x=%h c=%b e=%b rdy=%b",
                 i, x, committed, err, wr_ready, busy, m_x, m_comm, m_err, m_ready());
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_out_of_range();
    test_clear();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
